// File: rtl/light_separator_mc_if.sv
// Bus bundle for light_separator_mc: APB register port plus the pixel stream in/out.
// With LS_FRAME_IRQ_EN defined the bundle also carries the frame-done interrupt.
interface light_separator_mc_if #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned NUM_CH      = 3,
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned PDATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]        PADDR;
    logic                         PSEL;
    logic                         PENABLE;
    logic                         PWRITE;
    logic [PDATA_WIDTH-1:0]       PWDATA;
    logic [PDATA_WIDTH-1:0]       PRDATA;

    logic [NUM_CH*DATA_WIDTH-1:0] ImInput;
    logic                         in_valid;
    logic                         in_sof;
    logic                         in_eof;
    logic                         in_ready;

    logic [NUM_CH*DATA_WIDTH-1:0] ImOutput;
    logic [NUM_CH-1:0]            out_mask;
    logic                         out_eof;
    logic                         out_valid;
    logic                         out_ready;

`ifdef LS_FRAME_IRQ_EN
    logic                         irq;

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output ImInput, in_valid, in_sof, in_eof, out_ready,
        input  PRDATA, in_ready, ImOutput, out_mask, out_eof, out_valid, irq
    );

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  ImInput, in_valid, in_sof, in_eof, out_ready,
        output PRDATA, in_ready, ImOutput, out_mask, out_eof, out_valid, irq
    );
`else
    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output ImInput, in_valid, in_sof, in_eof, out_ready,
        input  PRDATA, in_ready, ImOutput, out_mask, out_eof, out_valid
    );

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  ImInput, in_valid, in_sof, in_eof, out_ready,
        output PRDATA, in_ready, ImOutput, out_mask, out_eof, out_valid
    );
`endif
endinterface

// File: rtl/light_separator_mc.sv
// N-channel light/dark separator: per-channel thresholds, lit mask, per-frame lit counters, zero-wait APB slave.
// Optional frame-done interrupt (irq, CTRL[3] IRQ_EN) is built when LS_FRAME_IRQ_EN is defined.
module light_separator_mc #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned NUM_CH      = 3,
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned PDATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH   = 20
) (
    input  logic                clk,
    input  logic                rst,
    light_separator_mc_if.slave bus
);
    localparam int unsigned PIX_WIDTH    = NUM_CH * DATA_WIDTH;
    localparam int unsigned ADDR_CTRL    = 32'h00;
    localparam int unsigned ADDR_STATUS  = 32'h04;
    localparam int unsigned ADDR_FRAMES  = 32'h08;
    localparam int unsigned THRESH_BASE  = 32'h10;
    localparam int unsigned COUNT_BASE   = 32'h40;
    localparam logic [DATA_WIDTH-1:0] THRESH_RST = DATA_WIDTH'(1) << (DATA_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX    = '1;

    // Control / status registers
    logic                   r_enable;
    logic                   r_mode;
    logic                   r_frame_done;
    logic [PDATA_WIDTH-1:0] r_frame_cnt;
    logic [PDATA_WIDTH-1:0] r_prdata;

    // Pipeline stage 1 (compare results + pixel) and stage 2 (outputs)
    logic                   r_s1_valid;
    logic [PIX_WIDTH-1:0]   r_s1_pix;
    logic [NUM_CH-1:0]      r_s1_lit;
    logic                   r_s1_eof;
    logic                   r_s1_enable;
    logic                   r_s1_mode;
    logic                   r_out_valid;
    logic [PIX_WIDTH-1:0]   r_out_pix;
    logic [NUM_CH-1:0]      r_out_mask;
    logic                   r_out_eof;

    logic                   w_en;
    logic                   w_accept;
    logic                   w_wr;
    logic                   w_rd_setup;
    logic                   w_wr_ctrl;
    logic                   w_clr;
    logic                   w_w1c;
    logic                   w_count_ev;
    logic                   w_frame_end;
    logic [NUM_CH-1:0]      w_lit;
    logic [PIX_WIDTH-1:0]   w_s2_pix;
    logic [NUM_CH-1:0]      w_s2_mask;
    logic [PDATA_WIDTH-1:0] w_rd_ch [NUM_CH];
    logic [PDATA_WIDTH-1:0] w_rdata;
    logic                   w_unused_pwdata;

    assign w_en        = !r_out_valid || bus.out_ready;
    assign w_accept    = bus.in_valid && w_en;
    assign w_wr        = bus.PSEL && bus.PENABLE && bus.PWRITE;
    assign w_rd_setup  = bus.PSEL && !bus.PENABLE && !bus.PWRITE;
    assign w_wr_ctrl   = w_wr && (bus.PADDR == ADDR_WIDTH'(ADDR_CTRL));
    assign w_clr       = w_wr_ctrl && bus.PWDATA[2];
    assign w_w1c       = w_wr && (bus.PADDR == ADDR_WIDTH'(ADDR_STATUS)) && bus.PWDATA[0];
    assign w_count_ev  = w_accept && r_enable;
    assign w_frame_end = w_count_ev && bus.in_eof;
    assign w_unused_pwdata = ^bus.PWDATA;

    // Per-channel threshold, compare, live/frame counters and output select
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DATA_WIDTH-1:0] r_thresh;
        logic [CNT_WIDTH-1:0]  r_live;
        logic [CNT_WIDTH-1:0]  r_count;
        logic [DATA_WIDTH-1:0] w_pix;
        logic [DATA_WIDTH-1:0] w_s1_pix;
        logic [CNT_WIDTH-1:0]  w_base;
        logic [CNT_WIDTH-1:0]  w_nxt;
        logic                  w_wr_thresh;

        assign w_pix       = bus.ImInput[c*DATA_WIDTH +: DATA_WIDTH];
        assign w_lit[c]    = (w_pix >= r_thresh);
        assign w_base      = bus.in_sof ? '0 : r_live;
        assign w_nxt       = (w_base == CNT_MAX) ? CNT_MAX : w_base + CNT_WIDTH'(w_lit[c]);
        assign w_wr_thresh = w_wr && (bus.PADDR == ADDR_WIDTH'(THRESH_BASE + 4 * c));

        always_ff @(posedge clk) begin
            if (rst) begin
                r_thresh <= THRESH_RST;
            end else if (w_wr_thresh) begin
                r_thresh <= bus.PWDATA[DATA_WIDTH-1:0];
            end
        end

        // CLR beats a same-edge frame end; sof reloads, eof publishes and restarts
        always_ff @(posedge clk) begin
            if (rst || w_clr) begin
                r_live  <= '0;
                r_count <= '0;
            end else if (w_count_ev) begin
                if (bus.in_eof) begin
                    r_count <= w_nxt;
                    r_live  <= '0;
                end else begin
                    r_live  <= w_nxt;
                end
            end
        end

        assign w_s1_pix = r_s1_pix[c*DATA_WIDTH +: DATA_WIDTH];
        assign w_s2_mask[c] = r_s1_enable && r_s1_lit[c];
        assign w_s2_pix[c*DATA_WIDTH +: DATA_WIDTH] =
            (!r_s1_enable || (r_s1_lit[c] ^ r_s1_mode)) ? w_s1_pix : '0;

        assign w_rd_ch[c] =
            (bus.PADDR == ADDR_WIDTH'(THRESH_BASE + 4 * c)) ? PDATA_WIDTH'(r_thresh) :
            (bus.PADDR == ADDR_WIDTH'(COUNT_BASE + 4 * c))  ? PDATA_WIDTH'(r_count)  : '0;
    end

`ifdef LS_FRAME_IRQ_EN
    logic r_irq_en;
    logic r_irq;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_irq_en <= bus.PWDATA[3];
            end
            r_irq <= r_frame_done && r_irq_en;
        end
    end

    assign bus.irq = r_irq;
`endif

    // CTRL fields; CLR is a pulse and never stored
    always_ff @(posedge clk) begin
        if (rst) begin
            r_enable <= 1'b0;
            r_mode   <= 1'b0;
        end else if (w_wr_ctrl) begin
            r_enable <= bus.PWDATA[0];
            r_mode   <= bus.PWDATA[1];
        end
    end

    // FRAME_DONE: a set on the same edge as a W1C wins
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_done <= 1'b0;
        end else if (w_frame_end) begin
            r_frame_done <= 1'b1;
        end else if (w_w1c) begin
            r_frame_done <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_clr) begin
            r_frame_cnt <= '0;
        end else if (w_frame_end) begin
            r_frame_cnt <= r_frame_cnt + PDATA_WIDTH'(1);
        end
    end

    // Two-stage pixel pipeline, advancing together whenever the output is free
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_pix    <= '0;
            r_s1_lit    <= '0;
            r_s1_eof    <= 1'b0;
            r_s1_enable <= 1'b0;
            r_s1_mode   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_pix   <= '0;
            r_out_mask  <= '0;
            r_out_eof   <= 1'b0;
        end else if (w_en) begin
            r_s1_valid  <= bus.in_valid;
            r_s1_pix    <= bus.ImInput;
            r_s1_lit    <= w_lit;
            r_s1_eof    <= bus.in_eof;
            r_s1_enable <= r_enable;
            r_s1_mode   <= r_mode;
            r_out_valid <= r_s1_valid;
            r_out_pix   <= w_s2_pix;
            r_out_mask  <= w_s2_mask;
            r_out_eof   <= r_s1_eof;
        end
    end

    // APB read decode
    always_comb begin
        w_rdata = '0;
        if (bus.PADDR == ADDR_WIDTH'(ADDR_CTRL)) begin
`ifdef LS_FRAME_IRQ_EN
            w_rdata = PDATA_WIDTH'({r_irq_en, 1'b0, r_mode, r_enable});
`else
            w_rdata = PDATA_WIDTH'({r_mode, r_enable});
`endif
        end else if (bus.PADDR == ADDR_WIDTH'(ADDR_STATUS)) begin
            w_rdata = PDATA_WIDTH'(r_frame_done);
        end else if (bus.PADDR == ADDR_WIDTH'(ADDR_FRAMES)) begin
            w_rdata = r_frame_cnt;
        end else begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                w_rdata = w_rdata | w_rd_ch[c];
            end
        end
    end

    // Read data captured in the setup phase, held through the access phase
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prdata <= '0;
        end else if (w_rd_setup) begin
            r_prdata <= w_rdata;
        end
    end

    assign bus.PRDATA    = r_prdata;
    assign bus.in_ready  = w_en;
    assign bus.ImOutput  = r_out_pix;
    assign bus.out_mask  = r_out_mask;
    assign bus.out_eof   = r_out_eof;
    assign bus.out_valid = r_out_valid;
endmodule

// File: tb/tb_light_separator_mc.sv
// Directed self-checking bench for light_separator_mc (3 channels, 4-bit counters for saturation).
// irq checks are compiled in when LS_FRAME_IRQ_EN is defined.
module tb_light_separator_mc;
    localparam int unsigned DW   = 8;
    localparam int unsigned NCH  = 3;
    localparam int unsigned AW   = 8;
    localparam int unsigned PW   = 32;
    localparam int unsigned CW   = 4;
    localparam int unsigned PIXW = NCH * DW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned n_rcv = 0;
    int unsigned n_bp_low = 0;
    logic [PIXW-1:0] bp_held;
    bit bp_stalled = 1'b0;
    logic [PW-1:0] rd;

    light_separator_mc_if #(.DATA_WIDTH(DW), .NUM_CH(NCH), .ADDR_WIDTH(AW), .PDATA_WIDTH(PW)) bus ();

    light_separator_mc #(
        .DATA_WIDTH(DW), .NUM_CH(NCH), .ADDR_WIDTH(AW), .PDATA_WIDTH(PW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apb_write(input logic [AW-1:0] addr, input logic [PW-1:0] data);
        bus.PADDR = addr; bus.PWDATA = data; bus.PWRITE = 1'b1;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0;
        step();
        bus.PENABLE = 1'b1;
        step();
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [AW-1:0] addr, output logic [PW-1:0] data);
        bus.PADDR = addr; bus.PWRITE = 1'b0;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0;
        step();
        bus.PENABLE = 1'b1;
        data = bus.PRDATA;
        step();
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    endtask

    task automatic apb_check(input string tag, input logic [AW-1:0] addr, input logic [PW-1:0] exp);
        logic [PW-1:0] d;
        apb_read(addr, d);
        chk(tag, 64'(d), 64'(exp));
    endtask

    // Present one pixel and wait (bounded) until it is accepted; leaves in_valid high
    task automatic send_pix(input logic [PIXW-1:0] pix, input logic sof, input logic eof);
        logic acc;
        acc = 1'b0;
        bus.ImInput = pix; bus.in_sof = sof; bus.in_eof = eof; bus.in_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            acc = bus.in_ready;
            step();
            if (acc) break;
        end
        if (!acc) chk("send_timeout", 64'(acc), 64'd1);
        bus.in_sof = 1'b0; bus.in_eof = 1'b0;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_eof = 1'b0;
    endtask

    function automatic logic [PIXW-1:0] bp_pix(input int i);
        logic [PIXW-1:0] v;
        v = 24'h102030 + 24'(i) * 24'h010101;
        return v;
    endfunction

    initial begin
        bus.PADDR = '0; bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PWDATA = '0;
        bus.ImInput = '0; bus.out_ready = 1'b1;
        idle();

        // Reset
        step();
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_prdata", 64'(bus.PRDATA), 64'd0);
        step(); step();
        rst = 1'b0;
        step();
        chk("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        apb_check("rst_ctrl", 8'h00, 32'h0);
        apb_check("rst_thresh0", 8'h10, 32'h80);
        apb_check("rst_thresh2", 8'h18, 32'h80);
        apb_check("rst_count0", 8'h40, 32'h0);
        apb_check("rst_status", 8'h04, 32'h0);
        apb_check("rst_frames", 8'h08, 32'h0);

        // Thresholds and basic light/dark separation
        apb_write(8'h10, 32'h40);
        apb_write(8'h14, 32'h80);
        apb_write(8'h18, 32'hC0);
        apb_check("thresh2_rb", 8'h18, 32'hC0);
        apb_check("unmapped_rd", 8'h0C, 32'h0);
        apb_write(8'h00, 32'h1);
        send_pix(24'h505050, 1'b0, 1'b0);
        idle();
        chk("lat_not_yet", 64'(bus.out_valid), 64'd0);
        step();
        chk("light_valid", 64'(bus.out_valid), 64'd1);
        chk("light_pix", 64'(bus.ImOutput), 64'h000050);
        chk("light_mask", 64'(bus.out_mask), 64'b001);
        step();
        apb_write(8'h00, 32'h3);
        send_pix(24'h505050, 1'b0, 1'b0);
        idle();
        step();
        chk("dark_pix", 64'(bus.ImOutput), 64'h505000);
        chk("dark_mask", 64'(bus.out_mask), 64'b001);
        step();
        apb_write(8'h00, 32'h0);
        send_pix(24'h505050, 1'b0, 1'b1);
        idle();
        step();
        chk("bypass_pix", 64'(bus.ImOutput), 64'h505050);
        chk("bypass_mask", 64'(bus.out_mask), 64'b000);
        chk("bypass_eof", 64'(bus.out_eof), 64'd1);
        step();
        apb_check("bypass_no_frame", 8'h08, 32'h0);

        // 10-pixel frame, 7 lit on ch0 (0x40 sits exactly on the threshold)
        apb_write(8'h00, 32'h1);
        begin
            logic [7:0] ch0 [10];
            ch0 = '{8'h40, 8'h3F, 8'hFF, 8'h10, 8'h80, 8'h41, 8'h00, 8'h90, 8'hA0, 8'h50};
            for (int i = 0; i < 10; i++) send_pix({16'h0000, ch0[i]}, 1'(i == 0), 1'(i == 9));
        end
        idle();
        step(); step();
        apb_check("frame_count0", 8'h40, 32'd7);
        apb_check("frame_count1", 8'h44, 32'd0);
        apb_check("frame_cnt1", 8'h08, 32'd1);
        apb_check("status_set", 8'h04, 32'd1);
        apb_write(8'h04, 32'h1);
        apb_check("status_w1c", 8'h04, 32'd0);

        // Backpressure: 20 pixels, out_ready low for 5 cycles mid-stream
        apb_write(8'h00, 32'h0);
        fork
            begin
                for (int i = 0; i < 20; i++) send_pix(bp_pix(i), 1'b0, 1'b0);
                idle();
            end
            begin
                for (int cyc = 0; cyc < 40; cyc++) begin
                    bus.out_ready = !(cyc >= 5 && cyc < 10);
                    step();
                end
                bus.out_ready = 1'b1;
            end
            begin
                for (int k = 0; k < 45; k++) begin
                    @(negedge clk);
                    if (!bus.in_ready) n_bp_low++;
                    if (bp_stalled) chk("bp_hold", 64'(bus.ImOutput), 64'(bp_held));
                    bp_stalled = bus.out_valid && !bus.out_ready;
                    bp_held = bus.ImOutput;
                    if (bus.out_valid && bus.out_ready) begin
                        if (n_rcv < 20) chk($sformatf("bp_pix%0d", n_rcv), 64'(bus.ImOutput), 64'(bp_pix(int'(n_rcv))));
                        n_rcv++;
                    end
                end
            end
        join
        chk("bp_received", 64'(n_rcv), 64'd20);
        chk("bp_in_ready_dropped", 64'(n_bp_low != 0), 64'd1);

        // One-pixel frame lit on ch1 only (0x80 on threshold, 0xBF just under 0xC0)
        apb_write(8'h00, 32'h1);
        send_pix(24'hBF8000, 1'b1, 1'b1);
        idle();
        step(); step();
        apb_check("one_pix_count0", 8'h40, 32'd0);
        apb_check("one_pix_count1", 8'h44, 32'd1);
        apb_check("one_pix_count2", 8'h48, 32'd0);
        apb_check("one_pix_frames", 8'h08, 32'd2);

        // 19 lit pixels with 4-bit counters saturate at 15
        for (int i = 0; i < 19; i++) send_pix(24'h0000FF, 1'(i == 0), 1'(i == 18));
        idle();
        step(); step();
        apb_check("sat_count0", 8'h40, 32'd15);
        apb_check("sat_count1", 8'h44, 32'd0);
        apb_check("sat_frames", 8'h08, 32'd3);

        // CLR clears counters and frame count and does not stick in CTRL
        apb_write(8'h00, 32'h5);
        apb_check("clr_count0", 8'h40, 32'd0);
        apb_check("clr_frames", 8'h08, 32'd0);
        apb_check("clr_ctrl_rb", 8'h00, 32'h1);

        // IRQ_EN bit: writable only when the irq feature is built
        apb_write(8'h04, 32'h1);
        apb_write(8'h00, 32'h9);
`ifdef LS_FRAME_IRQ_EN
        apb_check("ctrl_irq_rb", 8'h00, 32'h9);
        chk("irq_idle", 64'(bus.irq), 64'd0);
        send_pix(24'h0000FF, 1'b1, 1'b1);
        idle();
        chk("irq_lag", 64'(bus.irq), 64'd0);
        step();
        chk("irq_set", 64'(bus.irq), 64'd1);
        apb_write(8'h04, 32'h1);
        chk("irq_still_high", 64'(bus.irq), 64'd1);
        step();
        chk("irq_cleared", 64'(bus.irq), 64'd0);
`else
        apb_check("ctrl_irq_rb", 8'h00, 32'h1);
`endif

        // Reset in the middle of a frame drops the partial count
        send_pix(24'h0000FF, 1'b1, 1'b0);
        send_pix(24'h0000FF, 1'b0, 1'b0);
        idle();
        rst = 1'b1;
        step();
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        step();
        rst = 1'b0;
        step();
`ifdef LS_FRAME_IRQ_EN
        chk("midrst_irq", 64'(bus.irq), 64'd0);
`endif
        apb_write(8'h00, 32'h1);
        send_pix(24'h0000FF, 1'b0, 1'b1);
        idle();
        step(); step();
        apb_check("midrst_count0", 8'h40, 32'd1);
        apb_check("midrst_frames", 8'h08, 32'd1);
        apb_check("midrst_thresh0", 8'h10, 32'h80);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
